set_assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate data cache for the pipeline's memory stage, sitting between the MMU physical address and the memory controller. Hits are served combinationally in the request cycle. Misses assert a stall to the hazard unit and run a word-by-word writeback/refill over a req/ack handshake to the next level. Set width, associativity and line length are parameters, so the same block serves as L1, L2 or L3.

---
 rtl/set_assoc_cache.sv | 197 +++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with combinational hits
// and a word-serial writeback/refill engine on a req/ack next-level port.
module set_assoc_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SET_WIDTH      = 5,
  parameter int WAYS           = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);
  localparam int WOFF  = $clog2(WORDS_PER_LINE);
  localparam int BOFF  = $clog2(DATA_WIDTH / 8);
  localparam int TAG_W = ADDR_WIDTH - SET_WIDTH - WOFF - BOFF;
  localparam int SETS  = 1 << SET_WIDTH;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [WOFF-1:0] LAST_BEAT = WOFF'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t                      state;
  logic [WAYS-1:0][SETS-1:0]   validArr;
  logic [WAYS-1:0][SETS-1:0]   dirtyArr;
  logic [SETS-1:0][WAY_W-1:0]  vicPtr;
  logic [TAG_W-1:0]            tagArr  [WAYS][SETS];
  logic [DATA_WIDTH-1:0]       dataArr [WAYS][SETS][WORDS_PER_LINE];

  logic [WAY_W-1:0]     mWay;
  logic [SET_WIDTH-1:0] mSet;
  logic [TAG_W-1:0]     mTag;
  logic                 mAllValid;
  logic [WOFF-1:0]      beat;
  logic [WOFF-1:0]      beatNext;

  logic [TAG_W-1:0]     reqTag;
  logic [SET_WIDTH-1:0] reqSet;
  logic [WOFF-1:0]      reqWord;
  logic                 tagMatch;
  logic                 freeFound;
  logic [WAY_W-1:0]     hitWay;
  logic [WAY_W-1:0]     freeWay;
  logic [WAY_W-1:0]     vicWay;
  logic                 hit;
  logic                 miss;

  function automatic logic [ADDR_WIDTH-1:0] beatAddr(input logic [TAG_W-1:0] t,
                                                     input logic [SET_WIDTH-1:0] s,
                                                     input logic [WOFF-1:0] b);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[ADDR_WIDTH-1 -: TAG_W] = t;
    a[BOFF+WOFF +: SET_WIDTH] = s;
    a[BOFF +: WOFF] = b;
    return a;
  endfunction

  assign reqTag   = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign reqSet   = req_addr[BOFF+WOFF +: SET_WIDTH];
  assign reqWord  = req_addr[BOFF +: WOFF];
  assign beatNext = beat + WOFF'(1);

  generate
    if (BOFF > 0) begin : genByteOffset
      logic unusedByteBits;
      assign unusedByteBits = ^req_addr[BOFF-1:0];
    end
  endgenerate

  always_comb begin
    tagMatch  = 1'b0;
    freeFound = 1'b0;
    hitWay    = '0;
    freeWay   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (validArr[w][reqSet] && (tagArr[w][reqSet] == reqTag)) begin
        tagMatch = 1'b1;
        hitWay   = WAY_W'(w);
      end
      if (!validArr[w][reqSet] && !freeFound) begin
        freeFound = 1'b1;
        freeWay   = WAY_W'(w);
      end
    end
    vicWay = freeFound ? freeWay : vicPtr[reqSet];
  end

  assign hit        = (state == IDLE) && req_valid && tagMatch;
  assign miss       = (state == IDLE) && req_valid && !tagMatch;
  assign stall      = (state != IDLE) || miss;
  assign resp_rdata = dataArr[hitWay][reqSet][reqWord];

  // Control state: FSM, tag/valid/dirty metadata, next-level port and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      validArr   <= '0;
      dirtyArr   <= '0;
      vicPtr     <= '0;
      beat       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            hit_count <= hit_count + 32'd1;
            if (req_write) dirtyArr[hitWay][reqSet] <= 1'b1;
          end else if (miss) begin
            miss_count <= miss_count + 32'd1;
            mWay       <= vicWay;
            mSet       <= reqSet;
            mTag       <= reqTag;
            mAllValid  <= !freeFound;
            beat       <= '0;
            mem_req    <= 1'b1;
            if (validArr[vicWay][reqSet] && dirtyArr[vicWay][reqSet]) begin
              state     <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= beatAddr(tagArr[vicWay][reqSet], reqSet, '0);
              mem_wdata <= dataArr[vicWay][reqSet][0];
            end else begin
              state    <= REFILL;
              mem_we   <= 1'b0;
              mem_addr <= beatAddr(reqTag, reqSet, '0);
              validArr[vicWay][reqSet] <= 1'b0;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            if (beat == LAST_BEAT) begin
              // The victim line is invalid from here until its refill completes.
              dirtyArr[mWay][mSet] <= 1'b0;
              validArr[mWay][mSet] <= 1'b0;
              state    <= REFILL;
              beat     <= '0;
              mem_we   <= 1'b0;
              mem_addr <= beatAddr(mTag, mSet, '0);
            end else begin
              beat      <= beatNext;
              mem_addr  <= beatAddr(tagArr[mWay][mSet], mSet, beatNext);
              mem_wdata <= dataArr[mWay][mSet][beatNext];
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            if (beat == LAST_BEAT) begin
              validArr[mWay][mSet] <= 1'b1;
              dirtyArr[mWay][mSet] <= 1'b0;
              tagArr[mWay][mSet]   <= mTag;
              if (mAllValid) vicPtr[mSet] <= (WAYS == 1) ? '0 : vicPtr[mSet] + WAY_W'(1);
              state   <= IDLE;
              beat    <= '0;
              mem_req <= 1'b0;
            end else begin
              beat     <= beatNext;
              mem_addr <= beatAddr(mTag, mSet, beatNext);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data array: store-hit byte merge and refill beats; contents are not reset.
  always_ff @(posedge clk) begin
    if (hit && req_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_byte_en[b]) dataArr[hitWay][reqSet][reqWord][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
    if ((state == REFILL) && mem_ack) dataArr[mWay][mSet][beat] <= mem_rdata;
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: cold fill, store merge, conflict writeback,
// slow next-level memory and reset during refill.
module tb_set_assoc_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byte_en;
  logic [31:0] resp_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks;
  int errors;
  int waitCycles;
  int waitCnt;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  beat_t beatLog[$];

  logic [31:0]   memArr [1024];
  logic [1023:0] memWritten;

  set_assoc_cache dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
    .resp_rdata(resp_rdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Next-level memory: unwritten words read as 0x1000_0000 | address.
  assign mem_ack   = mem_req && (waitCnt == waitCycles);
  assign mem_rdata = memWritten[mem_addr[11:2]] ? memArr[mem_addr[11:2]] : (32'h1000_0000 | mem_addr);

  always @(posedge clk) begin
    if (rst) memWritten <= '0;
    if (mem_req && mem_ack) begin
      beatLog.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
      if (mem_we) begin
        memArr[mem_addr[11:2]]     <= mem_wdata;
        memWritten[mem_addr[11:2]] <= 1'b1;
      end
    end
    if (mem_req && !mem_ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output int stalls, output logic [31:0] rd);
    int guard;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_byte_en = be;
    stalls = 0;
    guard  = 0;
    @(negedge clk);
    while (stall && guard < 200) begin
      stalls++;
      guard++;
      @(negedge clk);
    end
    rd = resp_rdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic checkBeats(input string tag, input int first, input int n, input logic we,
                            input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), beatLog[first+i].addr, base + 32'(4*i));
      check($sformatf("%s_we%0d", tag, i), {31'd0, beatLog[first+i].we}, {31'd0, we});
    end
  endtask

  initial begin
    int          st;
    int          guard;
    logic [31:0] rd;
    checks = 0; errors = 0; waitCycles = 0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_byte_en = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    @(posedge clk);
    #1;

    // Cold load of 0x100: four refill reads, five stall cycles.
    beatLog.delete();
    access(1'b0, 32'h100, 32'h0, 4'h0, st, rd);
    check("cold_stall", 32'(st), 32'd5);
    check("cold_rdata", rd, 32'h1000_0100);
    check("cold_beats", 32'(beatLog.size()), 32'd4);
    checkBeats("cold", 0, 4, 1'b0, 32'h100);
    check("cold_misses", miss_count, 32'd1);
    check("cold_hits", hit_count, 32'd1);

    // Store hit with partial byte enables, then read back the merged word.
    beatLog.delete();
    access(1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, st, rd);
    check("store_stall", 32'(st), 32'd0);
    access(1'b0, 32'h104, 32'h0, 4'h0, st, rd);
    check("merge_stall", 32'(st), 32'd0);
    check("merge_rdata", rd, 32'h1000_BEEF);
    check("merge_no_beats", 32'(beatLog.size()), 32'd0);
    check("merge_hits", hit_count, 32'd3);

    // Same set, second way still free: clean fill, no writeback.
    beatLog.delete();
    access(1'b0, 32'h300, 32'h0, 4'h0, st, rd);
    check("way1_stall", 32'(st), 32'd5);
    check("way1_rdata", rd, 32'h1000_0300);
    check("way1_beats", 32'(beatLog.size()), 32'd4);
    checkBeats("way1", 0, 4, 1'b0, 32'h300);

    // Set full: dirty 0x100 line is written back before 0x500 refills.
    beatLog.delete();
    access(1'b0, 32'h500, 32'h0, 4'h0, st, rd);
    check("evict_stall", 32'(st), 32'd9);
    check("evict_rdata", rd, 32'h1000_0500);
    check("evict_beats", 32'(beatLog.size()), 32'd8);
    checkBeats("evict_wb", 0, 4, 1'b1, 32'h100);
    checkBeats("evict_rf", 4, 4, 1'b0, 32'h500);
    check("evict_wdata0", beatLog[0].data, 32'h1000_0100);
    check("evict_wdata1", beatLog[1].data, 32'h1000_BEEF);
    check("evict_wdata2", beatLog[2].data, 32'h1000_0108);
    check("evict_wdata3", beatLog[3].data, 32'h1000_010C);
    check("evict_misses", miss_count, 32'd3);

    // Both ways resident.
    access(1'b0, 32'h300, 32'h0, 4'h0, st, rd);
    check("resident300_stall", 32'(st), 32'd0);
    check("resident300_rdata", rd, 32'h1000_0300);
    access(1'b0, 32'h50C, 32'h0, 4'h0, st, rd);
    check("resident50C_stall", 32'(st), 32'd0);
    check("resident50C_rdata", rd, 32'h1000_050C);
    check("resident_hits", hit_count, 32'd7);

    // Ack every third cycle: clean miss on 0x700 replaces way 1 via the victim pointer.
    waitCycles = 2;
    beatLog.delete();
    access(1'b0, 32'h708, 32'h0, 4'h0, st, rd);
    check("slow_stall", 32'(st), 32'd13);
    check("slow_rdata", rd, 32'h1000_0708);
    check("slow_beats", 32'(beatLog.size()), 32'd4);
    checkBeats("slow", 0, 4, 1'b0, 32'h700);
    check("slow_misses", miss_count, 32'd4);
    waitCycles = 0;

    // 0x100 comes back from memory carrying the written-back merge.
    access(1'b0, 32'h104, 32'h0, 4'h0, st, rd);
    check("refetch_stall", 32'(st), 32'd5);
    check("refetch_rdata", rd, 32'h1000_BEEF);
    check("refetch_misses", miss_count, 32'd5);
    check("refetch_hits", hit_count, 32'd9);

    // Reset while the refill is on beat 2.
    beatLog.delete();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h900;
    guard = 0;
    @(negedge clk);
    while (beatLog.size() < 2 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check("midrefill_req", {31'd0, mem_req}, 32'd1);
    check("midrefill_addr", mem_addr, 32'h908);
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_hits", hit_count, 32'd0);
    check("abort_misses", miss_count, 32'd0);
    @(posedge clk);
    #1;
    access(1'b0, 32'h900, 32'h0, 4'h0, st, rd);
    check("reload_stall", 32'(st), 32'd5);
    check("reload_rdata", rd, 32'h1000_0900);
    check("reload_misses", miss_count, 32'd1);
    check("reload_hits", hit_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
